mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the five-stage pipeline: sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Performs word loads and stores against an internal data memory with a parameterised multi-cycle access latency. Raises `stall` to freeze the front of the pipeline while an access is in flight. Presents load data on `mem_res`, which MEM/WB captures as its memory-result input.

## Interface
- `DEPTH`, 256: data memory size in 32-bit words; power of two.
- `LATENCY`, 2: cycles per access, including the completion cycle; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mem_read`  in  1  load request, from EX/MEM.
- `mem_write`  in  1  store request, from EX/MEM.
- `addr`  in  32  byte address; the ALU result from EX/MEM.
- `wdata`  in  32  store data.
- `mem_res`  out  32  load data; valid in the completion cycle of a load, otherwise 0.
- `stall`  out  1  hold EX/MEM and all upstream registers; insert a bubble into MEM/WB.
- `misaligned`  out  1  one-cycle flag: the request was dropped because `addr[1:0]` != 0.

## Operation
- **Request definition.**
  - `req` = (`mem_read` | `mem_write`) & (`addr[1:0]` == 0).
  - `mem_read` and `mem_write` asserted together are treated as a store; `mem_res` = 0.
- **Word index.** `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH×4.
- **FSM states.** IDLE, BUSY. The counter `cnt` is 4 bits wide.
  - IDLE, `req` = 1, LATENCY = 1: the access completes this cycle; stay in IDLE.
  - IDLE, `req` = 1, LATENCY > 1: go to BUSY with `cnt` = 1.
  - BUSY, `req` = 1, `cnt` < LATENCY-1: `cnt` increments.
  - BUSY, `req` = 1, `cnt` == LATENCY-1: this is the completion cycle; go to IDLE with `cnt` = 0.
  - BUSY, `req` = 0: the access is aborted (upstream flush). Go to IDLE with `cnt` = 0; no store commits.
- **Stall.**
  - `stall` = `req` & !`done`.
  - `done` = (LATENCY == 1) | (state == BUSY & `cnt` == LATENCY-1).
  - `stall` is combinational. Upstream holds `mem_read`, `mem_write`, `addr` and `wdata` stable while `stall` = 1.
- **Store.** The memory word is written on the rising edge that ends the completion cycle. No write happens on any other cycle.
- **Load.**
  - `mem_res` = mem[index], combinational, only in the completion cycle; 0 otherwise.
  - A store to the same word completing on the next request returns the new data on later loads.
- **Misaligned.**
  - `misaligned` = (`mem_read` | `mem_write`) & (`addr[1:0]` != 0), combinational.
  - No stall, no write, `mem_res` = 0.
- **Reset.**
  - While `rst` = 0: state = IDLE, `cnt` = 0, `stall` = 0, `mem_res` = 0, `misaligned` = 0.
  - Any access in progress is aborted with no write.
  - Memory contents are not cleared.

## Timing
- Access latency is exactly LATENCY cycles, measured from the first cycle `req` is seen in IDLE.
- `stall` is high for the first LATENCY-1 of those cycles.
- LATENCY = 1 gives zero stall cycles, a same-cycle load result, and a store at the end of that cycle.
- Back-to-back requests: the cycle after completion is in IDLE, so a new request starts immediately with no dead cycle.
- MEM/WB captures `mem_res` at the edge that ends the completion cycle.
- `stall` and `mem_res` combinationally depend on the inputs; this is a single pass through the memory read mux.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (IDLE = 0, BUSY = 1);
  - `WORD_W` = 32;
  - the `CNT_W` = 4 constant.
- Sub-module `data_mem_array`:
  - DEPTH×32 array;
  - asynchronous read port;
  - synchronous write port with write-enable;
  - no reset.
- FSM, counter, request decode and output muxing live in `mem_access_stage`.

## Test plan
- **Reset during BUSY.** LATENCY = 3, store 0xDEADBEEF to addr 0x10. Pull `rst` low during the cycle with `cnt` = 1. Required: `stall` = 0 and state IDLE after the reset edge; a later load of 0x10 does not return 0xDEADBEEF.
- **Store then load.** LATENCY = 2. Store 0x12345678 to addr 0x20, then load 0x20. Required: `stall` = 1 for exactly 1 cycle per access; `mem_res` = 0x12345678 in the load's second cycle and 0 in its first.
- **LATENCY = 1 back-to-back.** Store 0xA5A5A5A5 to addr 0x04, then immediately load 0x04. Required: `stall` never asserts; `mem_res` = 0xA5A5A5A5 in the load cycle.
- **Misaligned and wrap-around.**
  - Load from addr 0x22. Required: `misaligned` = 1 for 1 cycle, `stall` = 0, `mem_res` = 0.
  - With DEPTH = 256, store to 0x400 and then load 0x000. Required: the stored value is returned.
- **Abort mid-access.** LATENCY = 4, store 0x0000FFFF to addr 0x08. Drop `mem_write` at `cnt` = 2. Required: FSM returns to IDLE; word 0x08 is unchanged.
- **Read and write together.** Assert `mem_read` and `mem_write` together with addr 0x0C and `wdata` 0x77. Required: treated as a store; `mem_res` = 0 throughout; a later load of 0x0C returns 0x77.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-access stage: FSM state encoding,
// data word width and access-counter width.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

endpackage : mem_pkg

// File: rtl/data_mem_array.sv
// data_mem_array
// DEPTH x WORD_W data memory with one asynchronous read port and one
// synchronous write port sharing a single word index.
//
// Ports:
//   clk    in   clock; writes happen on the rising edge
//   we     in   write enable
//   idx    in   word index (read and write)
//   wdata  in   write data
//   rdata  out  read data, combinational from idx
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] memWords [DEPTH];

    assign rdata = memWords[idx];

    // NOTE: storage arrays get no reset; clearing them would force the
    // array out of RAM macros and into flops, and nothing relies on it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples the
        // pre-edge values regardless of statement order.
        if (we) begin
            memWords[idx] <= wdata;
        end
    end

endmodule : data_mem_array

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access pipeline stage. Performs aligned word loads and stores
// against an internal data memory that takes LATENCY cycles per access,
// stalling the upstream pipeline until the completion cycle.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   mem_read    in   load request
//   mem_write   in   store request (wins when both are set)
//   addr        in   byte address; only aligned addresses are accepted
//   wdata       in   store data
//   mem_res     out  load data in the completion cycle of a load, else 0
//   stall       out  hold upstream registers, bubble into MEM/WB
//   misaligned  out  request dropped because addr[1:0] != 0
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] mem_res,
    output logic              stall,
    output logic              misaligned
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;

    logic              anyReq;
    logic              aligned;
    logic              accessReq;
    logic              done;
    logic              complete;
    logic              memWe;
    logic [IDX_W-1:0]  wordIdx;
    logic [WORD_W-1:0] readWord;

    // Address bits above the memory size wrap; they are deliberately dropped.
    logic              unusedAddrBits;
    assign unusedAddrBits = ^addr[WORD_W-1:IDX_W+2];

    assign anyReq    = mem_read | mem_write;
    assign aligned   = (addr[1:0] == 2'b00);
    assign accessReq = anyReq & aligned;
    assign wordIdx   = addr[IDX_W+1:2];

    assign done     = (LATENCY == 1) || ((state == BUSY) && (cnt == LAST_CNT));
    // While reset is held every access is cancelled, so nothing completes.
    assign complete = rst & accessReq & done;
    assign memWe    = complete & mem_write;

    // Outputs are gated by rst so they read as idle while reset is held,
    // not only after the reset edge.
    assign stall      = rst & accessReq & ~done;
    assign misaligned = rst & anyReq & ~aligned;
    // A simultaneous read+write is a store and returns nothing.
    assign mem_res    = (complete && mem_read && !mem_write) ? readWord : '0;

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_data_mem_array (
        .clk   (clk),
        .we    (memWe),
        .idx   (wordIdx),
        .wdata (wdata),
        .rdata (readWord)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                // With LATENCY == 1 the access finishes in the IDLE cycle.
                if (accessReq && (LATENCY > 1)) begin
                    stateNext = BUSY;
                    cntNext   = CNT_W'(1);
                end
            end
            BUSY: begin
                // Dropping the request mid-access is an upstream flush:
                // abandon it, and the store never commits.
                if (!accessReq || (cnt == LAST_CNT)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

endmodule : mem_access_stage
